tdpram_rr_arbiter: RTL

// Round-robin arbiter that shares one TDPRAM port (A or B) between NREQ requesters.

---
 rtl/tdpram_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tdpram_rr_arbiter.sv
// Round-robin arbiter sharing one TDPRAM port among NREQ requesters.
// Registered RAM-side issue; read responses are routed back with a one-hot valid.
module tdpram_rr_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int NREQ  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int IDW  = $clog2(NREQ),
    localparam int SW   = WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ-1:0]       REQ_WE,
    input  logic [NREQ*AW-1:0]    REQ_ADDR,
    input  logic [NREQ*WIDTH-1:0] REQ_WDATA,
    input  logic [NREQ*SW-1:0]    REQ_WSTRB,
    output logic [NREQ-1:0]       RSP_VALID,
    output logic [WIDTH-1:0]      RSP_DATA,
    output logic [AW-1:0]         RAM_ADDR,
    output logic                  RAM_REN,
    output logic                  RAM_WEN,
    output logic [WIDTH-1:0]      RAM_WDATA,
    output logic [SW-1:0]         RAM_WSTRB,
    input  logic                  RAM_RVALID,
    input  logic [WIDTH-1:0]      RAM_RDATA
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             ren_q, ren_d;
    logic             wen_q, wen_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             tag1_v_q, tag1_v_d;
    logic [IDW-1:0]   tag1_id_q, tag1_id_d;
    logic             tag2_v_q, tag2_v_d;
    logic [IDW-1:0]   tag2_id_q, tag2_id_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]  grant;
    logic             accept;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   idx;

    // Search starts at ptr and wraps; reset suppresses any grant.
    always_comb begin
        grant  = '0;
        accept = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!accept && REQ_VALID[idx] && !RST) begin
                accept      = 1'b1;
                grant[idx]  = 1'b1;
                win_id      = idx;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        ren_d       = 1'b0;
        wen_d       = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        tag1_v_d    = 1'b0;
        tag1_id_d   = tag1_id_q;
        tag2_v_d    = tag1_v_q;
        tag2_id_d   = tag1_id_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            ptr_d     = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
            ren_d     = ~REQ_WE[win_id];
            wen_d     = REQ_WE[win_id];
            addr_d    = REQ_ADDR[int'(win_id)*AW +: AW];
            wdata_d   = REQ_WDATA[int'(win_id)*WIDTH +: WIDTH];
            wstrb_d   = REQ_WSTRB[int'(win_id)*SW +: SW];
            tag1_v_d  = ~REQ_WE[win_id];
            tag1_id_d = win_id;
        end
        // Second tag stage lines up with RAM_RVALID; stray RVALIDs are dropped.
        if (RAM_RVALID && tag2_v_q) begin
            rsp_valid_d[tag2_id_q] = 1'b1;
            rsp_data_d             = RAM_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q       <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            tag1_v_q    <= 1'b0;
            tag1_id_q   <= '0;
            tag2_v_q    <= 1'b0;
            tag2_id_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tag1_v_q    <= tag1_v_d;
            tag1_id_q   <= tag1_id_d;
            tag2_v_q    <= tag2_v_d;
            tag2_id_q   <= tag2_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign REQ_READY = grant;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RAM_ADDR  = addr_q;
    assign RAM_REN   = ren_q;
    assign RAM_WEN   = wen_q;
    assign RAM_WDATA = wdata_q;
    assign RAM_WSTRB = wstrb_q;

endmodule
